stopwatch_controller: RTL and testbench
=======================================

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 2: consecutive agreeing tick samples needed to accept a new button level (legal range 1-15).
REQ-002 CLK_50_MHz  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 CLK_100Hz  input  1  100 Hz square wave from the clock divider, treated as asynchronous.
REQ-005 start_stop_n  input  1  raw push button, active-low, asynchronous.
REQ-006 lap_n  input  1  raw push button, active-low, asynchronous.
REQ-007 clear_n  input  1  raw push button, active-low, asynchronous.
REQ-008 time_cs  output  8  displayed centiseconds, two BCD digits, 00-99.
REQ-009 time_s  output  8  displayed seconds, two BCD digits, 00-59.
REQ-010 time_m  output  8  displayed minutes, two BCD digits, 00-59.
REQ-011 running  output  1  high in RUN or LAP.
REQ-012 lap_hold  output  1  high in LAP (display frozen).
REQ-013 overflow  output  1  sticky wrap indicator.

Function
REQ-014 CLK_100Hz and each button SHALL pass through a two-flop synchroniser before any use.
REQ-015 tick SHALL be a one-cycle internal pulse per synchronised CLK_100Hz rising edge, asserted no later than 4 CLK_50_MHz cycles after the edge; no pulse on falling edges.
REQ-016 Each button SHALL be sampled only on tick cycles; its debounced level changes after DEBOUNCE_TICKS consecutive samples at the new level; any disagreeing sample restarts the count.
REQ-017 A press event SHALL be a one-cycle pulse on each debounced 1->0 transition; releases generate no event; a held button generates exactly one event.
REQ-018 State machine states: IDLE, RUN, STOP, LAP.
REQ-019 IDLE: start -> RUN; lap, clear -> no effect.
REQ-020 RUN: start -> STOP; lap -> LAP, capturing the live time into the display latch on that cycle; clear ignored.
REQ-021 LAP: lap -> RUN (display returns to live); start -> STOP (display returns to live); clear ignored.
REQ-022 STOP: start -> RUN, resuming from the held time; clear -> IDLE, zeroing live time, latch and overflow; lap ignored.
REQ-023 Same-cycle events SHALL be prioritised clear > start > lap; lower-priority events that cycle are discarded.
REQ-024 The live time SHALL advance by 1 cs on each tick in which the current (pre-transition) state is RUN or LAP.
REQ-025 BCD carry chain: cs 99 -> 00 carries into seconds; s 59 -> 00 carries into minutes; m 59 -> 00 wraps; no digit ever holds a value above 9.
REQ-026 Wrap from 59:59.99 to 00:00.00 SHALL set overflow, which stays high until clear is accepted in STOP or reset occurs; counting continues after the wrap.
REQ-027 Displayed time SHALL be the latch in LAP and the live time otherwise; outputs are registered, so the display reflects a live change one cycle after it.
REQ-028 running and lap_hold SHALL be registered decodes of the state and update in the cycle after the transition.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, all times and the latch to 00, overflow/running/lap_hold low, synchroniser and debounced levels high (released), and debounce counts to 0.
REQ-030 Reset asserted mid-run SHALL discard all in-flight presses and partial debounce counts; after release the block waits in IDLE.

Verification
REQ-031 Reset, then a start press held for 3 ticks -> exactly one event, running=1; after 150 ticks the display reads 00:01.50.
REQ-032 In RUN at 00:00.40, press lap -> lap_hold=1 and the display stays at 00:00.40 for 100 ticks while live time reaches 00:01.40; press lap -> display 00:01.40.
REQ-033 Preload via 359999 RUN ticks (display 59:59.99), then one more tick -> display 00:00.00, overflow=1; press start then clear -> IDLE, 00:00.00, overflow=0.
REQ-034 Drive start_stop_n low for less than one tick period, and separately glitch it so that samples alternate -> no event, state unchanged.
REQ-035 start and clear debounced low in the same cycle while in STOP -> IDLE, time zeroed, no RUN entry; the same pair in RUN -> STOP only.
REQ-036 Assert reset_n for 2 cycles while in LAP at 00:03.07 -> all outputs 0 immediately; the next start press begins counting from 00:00.00.

Source files
------------

// File: rtl/stopwatch_controller.sv
// Stopwatch controller: synchronises the 100 Hz reference and buttons, debounces presses,
// runs an IDLE/RUN/STOP/LAP machine and keeps a BCD mm:ss.cc time with lap freeze.
module stopwatch_controller #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic       CLK_50_MHz,
  input  logic       reset_n,
  input  logic       CLK_100Hz,
  input  logic       start_stop_n,
  input  logic       lap_n,
  input  logic       clear_n,
  output logic [7:0] time_cs,
  output logic [7:0] time_s,
  output logic [7:0] time_m,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

  logic [1:0] clk_sync;
  logic       clk_prev;
  logic [2:0] btn_meta, btn_sync;
  logic       tick;
  logic [2:0] db_level, press;
  logic [3:0] db_cnt [3];
  state_t     state, next_state;
  logic       start_evt, lap_evt, clear_evt;
  logic       clear_accept, lap_capture, counting;
  logic [7:0] live_cs, live_s, live_m;
  logic [7:0] latch_cs, latch_s, latch_m;
  logic [8:0] cs_inc, s_inc, m_inc;
  logic [23:0] disp_d;
  logic       running_d, lap_hold_d;

  // Bit 8 of the result is the carry out when the field rolls over from top to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      bcd_inc = 9'h100;
    else if (v[3:0] == 4'd9)
      bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '0;
      clk_prev <= 1'b0;
      btn_meta <= '1;
      btn_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], CLK_100Hz};
      clk_prev <= clk_sync[1];
      btn_meta <= {clear_n, lap_n, start_stop_n};
      btn_sync <= btn_meta;
    end
  end

  assign tick = clk_sync[1] & ~clk_prev;

  // A sample that agrees with the accepted level restarts the run of disagreeing samples.
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      db_level <= '1;
      press    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          if (btn_sync[i] == db_level[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] + 4'd1 == DB_LIMIT) begin
            db_level[i] <= btn_sync[i];
            db_cnt[i]   <= '0;
            press[i]    <= ~btn_sync[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign start_evt    = press[0];
  assign lap_evt      = press[1];
  assign clear_evt    = press[2];
  assign clear_accept = (state == STOP) && clear_evt;
  assign lap_capture  = (state == RUN) && lap_evt && !start_evt;
  assign counting     = tick && ((state == RUN) || (state == LAP));

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Clear outranks start, start outranks lap; events a state ignores fall through.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_evt) next_state = RUN;
      RUN: begin
        if (start_evt)    next_state = STOP;
        else if (lap_evt) next_state = LAP;
      end
      LAP: begin
        if (start_evt)    next_state = STOP;
        else if (lap_evt) next_state = RUN;
      end
      STOP: begin
        if (clear_evt)      next_state = IDLE;
        else if (start_evt) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running_d  = (state == RUN) || (state == LAP);
    lap_hold_d = (state == LAP);
    disp_d     = (state == LAP) ? {latch_m, latch_s, latch_cs} : {live_m, live_s, live_cs};
  end

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      lap_hold <= 1'b0;
      time_m   <= '0;
      time_s   <= '0;
      time_cs  <= '0;
    end else begin
      running  <= running_d;
      lap_hold <= lap_hold_d;
      {time_m, time_s, time_cs} <= disp_d;
    end
  end

  assign cs_inc = bcd_inc(live_cs, 8'h99);
  assign s_inc  = bcd_inc(live_s, 8'h59);
  assign m_inc  = bcd_inc(live_m, 8'h59);

  // Minutes rolling past 59 marks the sticky overflow but the count keeps going.
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      {live_m, live_s, live_cs}    <= '0;
      {latch_m, latch_s, latch_cs} <= '0;
      overflow                     <= 1'b0;
    end else if (clear_accept) begin
      {live_m, live_s, live_cs}    <= '0;
      {latch_m, latch_s, latch_cs} <= '0;
      overflow                     <= 1'b0;
    end else begin
      if (counting) begin
        live_cs <= cs_inc[7:0];
        if (cs_inc[8]) begin
          live_s <= s_inc[7:0];
          if (s_inc[8]) begin
            live_m <= m_inc[7:0];
            if (m_inc[8]) overflow <= 1'b1;
          end
        end
      end
      if (lap_capture) {latch_m, latch_s, latch_cs} <= {live_m, live_s, live_cs};
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: a vector table for the main state flow
// plus hand sequences for glitches, wrap, simultaneous presses and reset mid-lap.
module tb_stopwatch_controller;

  logic       CLK_50_MHz;
  logic       reset_n;
  logic       CLK_100Hz;
  logic       start_stop_n, lap_n, clear_n;
  logic [7:0] time_cs, time_s, time_m;
  logic       running, lap_hold, overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          btn;
    int          hold;
    int          ticks;
    logic        run;
    logic        lap;
    logic        ovf;
    logic [23:0] disp;
  } vec_t;

  vec_t vecs [15];

  stopwatch_controller #(.DEBOUNCE_TICKS(2)) dut (
    .CLK_50_MHz  (CLK_50_MHz),
    .reset_n     (reset_n),
    .CLK_100Hz   (CLK_100Hz),
    .start_stop_n(start_stop_n),
    .lap_n       (lap_n),
    .clear_n     (clear_n),
    .time_cs     (time_cs),
    .time_s      (time_s),
    .time_m      (time_m),
    .running     (running),
    .lap_hold    (lap_hold),
    .overflow    (overflow)
  );

  initial CLK_50_MHz = 1'b0;
  always #5 CLK_50_MHz = ~CLK_50_MHz;

  // One full 100 Hz period, squeezed to 8 system cycles so every tick fully settles.
  task automatic tick_pulse();
    @(negedge CLK_50_MHz) CLK_100Hz = 1'b1;
    repeat (4) @(negedge CLK_50_MHz);
    CLK_100Hz = 1'b0;
    repeat (4) @(negedge CLK_50_MHz);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      1: start_stop_n = v;
      2: lap_n        = v;
      3: clear_n      = v;
      default: ;
    endcase
  endtask

  task automatic apply_stimulus(input int b, input int hold, input int ticks);
    if (b != 0) begin
      @(negedge CLK_50_MHz) set_btn(b, 1'b0);
      repeat (hold) tick_pulse();
      set_btn(b, 1'b1);
      repeat (2) tick_pulse();
    end
    repeat (ticks) tick_pulse();
  endtask

  task automatic check_output(input string name, input logic run, input logic lap,
                              input logic ovf, input logic [23:0] disp);
    total++;
    if ({running, lap_hold, overflow, time_m, time_s, time_cs} !== {run, lap, ovf, disp}) begin
      bad++;
      $display("[TB] FAIL %s: got run=%b lap=%b ovf=%b time=%h:%h.%h, expected run=%b lap=%b ovf=%b time=%h:%h.%h",
               name, running, lap_hold, overflow, time_m, time_s, time_cs,
               run, lap, ovf, disp[23:16], disp[15:8], disp[7:0]);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 3, 147, 1'b1, 1'b0, 1'b0, 24'h000150};
    vecs[1]  = '{2, 2, 96,  1'b1, 1'b1, 1'b0, 24'h000152};
    vecs[2]  = '{2, 2, 0,   1'b1, 1'b0, 1'b0, 24'h000254};
    vecs[3]  = '{1, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000256};
    vecs[4]  = '{0, 0, 10,  1'b0, 1'b0, 1'b0, 24'h000256};
    vecs[5]  = '{2, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000256};
    vecs[6]  = '{1, 2, 2,   1'b1, 1'b0, 1'b0, 24'h000260};
    vecs[7]  = '{3, 2, 0,   1'b1, 1'b0, 1'b0, 24'h000264};
    vecs[8]  = '{2, 2, 0,   1'b1, 1'b1, 1'b0, 24'h000266};
    vecs[9]  = '{3, 2, 0,   1'b1, 1'b1, 1'b0, 24'h000266};
    vecs[10] = '{1, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000274};
    vecs[11] = '{3, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[12] = '{2, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[13] = '{3, 2, 0,   1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[14] = '{1, 1, 0,   1'b0, 1'b0, 1'b0, 24'h000000};

    reset_n      = 1'b0;
    CLK_100Hz    = 1'b0;
    start_stop_n = 1'b1;
    lap_n        = 1'b1;
    clear_n      = 1'b1;
    repeat (3) @(negedge CLK_50_MHz);
    check_output("reset", 1'b0, 1'b0, 1'b0, 24'h000000);
    reset_n = 1'b1;
    @(negedge CLK_50_MHz);

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].btn, vecs[i].hold, vecs[i].ticks);
      check_output($sformatf("vec%0d", i), vecs[i].run, vecs[i].lap, vecs[i].ovf, vecs[i].disp);
    end

    // Short pulse between ticks, then alternating samples: neither may debounce.
    @(negedge CLK_50_MHz) start_stop_n = 1'b0;
    repeat (2) @(negedge CLK_50_MHz);
    start_stop_n = 1'b1;
    repeat (3) tick_pulse();
    check_output("short_glitch", 1'b0, 1'b0, 1'b0, 24'h000000);
    for (int i = 0; i < 6; i++) begin
      start_stop_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick_pulse();
    end
    start_stop_n = 1'b1;
    repeat (2) tick_pulse();
    check_output("alt_glitch", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Wrap: preload 59:59.90 while stopped, then count through the top.
    apply_stimulus(1, 2, 0);
    apply_stimulus(1, 2, 0);
    check_output("pre_stop", 1'b0, 1'b0, 1'b0, 24'h000004);
    @(negedge CLK_50_MHz);
    force dut.live_m  = 8'h59;
    force dut.live_s  = 8'h59;
    force dut.live_cs = 8'h90;
    @(negedge CLK_50_MHz);
    release dut.live_m;
    release dut.live_s;
    release dut.live_cs;
    repeat (2) @(negedge CLK_50_MHz);
    check_output("preload", 1'b0, 1'b0, 1'b0, 24'h595990);
    apply_stimulus(1, 2, 7);
    check_output("top", 1'b1, 1'b0, 1'b0, 24'h595999);
    tick_pulse();
    check_output("wrap", 1'b1, 1'b0, 1'b1, 24'h000000);
    repeat (5) tick_pulse();
    check_output("after_wrap", 1'b1, 1'b0, 1'b1, 24'h000005);
    apply_stimulus(1, 2, 0);
    check_output("ovf_stop", 1'b0, 1'b0, 1'b1, 24'h000007);
    apply_stimulus(3, 2, 0);
    check_output("ovf_clear", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Start and clear debounced together: RUN takes start, STOP takes clear.
    apply_stimulus(1, 2, 0);
    @(negedge CLK_50_MHz) begin start_stop_n = 1'b0; clear_n = 1'b0; end
    repeat (2) tick_pulse();
    start_stop_n = 1'b1; clear_n = 1'b1;
    repeat (2) tick_pulse();
    check_output("pair_run", 1'b0, 1'b0, 1'b0, 24'h000004);
    start_stop_n = 1'b0; clear_n = 1'b0;
    repeat (2) tick_pulse();
    start_stop_n = 1'b1; clear_n = 1'b1;
    repeat (2) tick_pulse();
    check_output("pair_stop", 1'b0, 1'b0, 1'b0, 24'h000000);
    repeat (3) tick_pulse();
    check_output("pair_idle", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Reset while in LAP at 00:03.07 with a start press half debounced.
    apply_stimulus(1, 2, 303);
    apply_stimulus(2, 2, 0);
    check_output("lap_307", 1'b1, 1'b1, 1'b0, 24'h000307);
    start_stop_n = 1'b0;
    tick_pulse();
    reset_n = 1'b0;
    #1;
    check_output("reset_async", 1'b0, 1'b0, 1'b0, 24'h000000);
    @(negedge CLK_50_MHz) start_stop_n = 1'b1;
    @(negedge CLK_50_MHz) reset_n = 1'b1;
    repeat (2) tick_pulse();
    check_output("post_reset", 1'b0, 1'b0, 1'b0, 24'h000000);
    apply_stimulus(1, 2, 0);
    check_output("restart", 1'b1, 1'b0, 1'b0, 24'h000002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
